// File: rtl/config_pkg.sv
// Minimal core configuration: only the fields the trace scheduler reads.
package config_pkg;

    typedef struct packed {
        int unsigned NrCommitPorts;
        int unsigned XLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{NrCommitPorts: 32'd2, XLEN: 32'd32};

endpackage

// File: rtl/iti_pkg.sv
// Shared types for the instruction trace interface scheduler.
package iti_pkg;

    localparam int unsigned ITI_XLEN        = config_pkg::cva6_cfg_empty.XLEN;
    localparam int unsigned ITI_IRETIRE_LEN = 32;
    localparam int unsigned ITI_ITYPE_LEN   = 3;
    localparam int unsigned ITI_CAUSE_LEN   = 5;

    typedef enum logic [1:0] {
        ITI_SCHED_OFF,
        ITI_SCHED_ACTIVE,
        ITI_SCHED_DRAIN
    } iti_sched_state_e;

    typedef struct packed {
        logic [ITI_IRETIRE_LEN-1:0] iretire;
        logic [ITI_ITYPE_LEN-1:0]   itype;
        logic                       ilastsize;
        logic [ITI_XLEN-1:0]        iaddr;
        logic [1:0]                 priv;
        logic [ITI_CAUSE_LEN-1:0]   cause;
        logic [ITI_XLEN-1:0]        tval;
        logic [63:0]                cycles;
        logic                       lost;
    } iti_sched_rec_t;

endpackage

// File: rtl/iti_multi_push_fifo.sv
// NP-write / 1-read record FIFO; head is the registered slot, zero when empty.
module iti_multi_push_fifo import iti_pkg::*; #(
    parameter int unsigned NP    = 2,
    parameter int unsigned DEPTH = 8,
    parameter type         rec_t = iti_sched_rec_t,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(NP + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [CW-1:0]    push_cnt_i,
    input  rec_t [NP-1:0]    push_data_i,
    input  logic             pop_i,
    output logic [AW:0]      free_o,
    output logic [AW:0]      fill_o,
    output logic             valid_o,
    output rec_t             head_o
);

    localparam int unsigned FW = AW + 1;

    rec_t          mem [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [FW-1:0] cnt_q, cnt_d;
    logic          valid_q;

    assign cnt_d = cnt_q + FW'(push_cnt_i) - FW'(pop_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_q + AW'(push_cnt_i);
            rptr_q  <= rptr_q + AW'(pop_i);
            cnt_q   <= cnt_d;
            valid_q <= (cnt_d != '0);
        end
    end

    // Storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NP; i++) begin
            if (CW'(i) < push_cnt_i) begin
                mem[wptr_q + AW'(i)] <= push_data_i[i];
            end
        end
    end

    assign free_o  = FW'(DEPTH) - cnt_q;
    assign fill_o  = cnt_q;
    assign valid_o = valid_q;
    assign head_o  = valid_q ? mem[rptr_q] : '0;

endmodule

// File: rtl/iti_trace_scheduler.sv
// Queues up to NP trace records per cycle and issues one per cycle to the encoder.
// Optional drop counter built when ITI_SCHED_DROP_CNT_EN is defined.
module iti_trace_scheduler import iti_pkg::*; #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg     = config_pkg::cva6_cfg_empty,
    parameter int unsigned           FIFO_DEPTH  = 8,
    parameter int unsigned           IRETIRE_LEN = 32,
    parameter int unsigned           ITYPE_LEN   = 3,
    parameter int unsigned           CAUSE_LEN   = 5
) (
    input  logic                                                 clk_i,
    input  logic                                                 rst_ni,
    input  logic                                                 trace_enable_i,
    input  logic [CVA6Cfg.NrCommitPorts-1:0]                     valid_i,
    input  logic [CVA6Cfg.NrCommitPorts-1:0][IRETIRE_LEN-1:0]    iretire_i,
    input  logic [CVA6Cfg.NrCommitPorts-1:0][ITYPE_LEN-1:0]      itype_i,
    input  logic [CVA6Cfg.NrCommitPorts-1:0]                     ilastsize_i,
    input  logic [CVA6Cfg.NrCommitPorts-1:0][CVA6Cfg.XLEN-1:0]   iaddr_i,
    input  logic [1:0]                                           priv_i,
    input  logic [CAUSE_LEN-1:0]                                 cause_i,
    input  logic [CVA6Cfg.XLEN-1:0]                              tval_i,
    input  logic [63:0]                                          cycles_i,
    output logic                                                 out_valid_o,
    input  logic                                                 out_ready_i,
    output logic [IRETIRE_LEN-1:0]                               out_iretire_o,
    output logic [ITYPE_LEN-1:0]                                 out_itype_o,
    output logic                                                 out_ilastsize_o,
    output logic [CVA6Cfg.XLEN-1:0]                              out_iaddr_o,
    output logic [1:0]                                           out_priv_o,
    output logic [CAUSE_LEN-1:0]                                 out_cause_o,
    output logic [CVA6Cfg.XLEN-1:0]                              out_tval_o,
    output logic [63:0]                                          out_cycles_o,
    output logic                                                 out_lost_o,
    output logic [$clog2(FIFO_DEPTH):0]                          fill_o,
    output logic                                                 busy_o,
    output logic [31:0]                                          drop_count_o
);

    localparam int unsigned NP   = CVA6Cfg.NrCommitPorts;
    localparam int unsigned XLEN = CVA6Cfg.XLEN;
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned FW   = AW + 1;
    localparam int unsigned CW   = $clog2(NP + 1);

    iti_sched_state_e         state_q;
    logic                     busy_q;
    logic                     lost_pending_q;
    logic                     capture, overflow, pop, fifo_valid;
    logic [CW-1:0]            nvalid, push_cnt;
    logic [CW-1:0]            pre [NP];
    logic [FW-1:0]            free, fill;
    iti_sched_rec_t [NP-1:0]  port_rec, push_data;
    iti_sched_rec_t           head;

    // Per-port record build and prefix count of valid ports below each port.
    always_comb begin
        nvalid   = '0;
        port_rec = '0;
        for (int p = 0; p < NP; p++) begin
            pre[p]   = nvalid;
            nvalid   = nvalid + CW'(valid_i[p]);
            port_rec[p].iretire   = ITI_IRETIRE_LEN'(iretire_i[p]);
            port_rec[p].itype     = ITI_ITYPE_LEN'(itype_i[p]);
            port_rec[p].ilastsize = ilastsize_i[p];
            port_rec[p].iaddr     = ITI_XLEN'(iaddr_i[p]);
            port_rec[p].priv      = priv_i;
            port_rec[p].cycles    = cycles_i;
            if (p == 0) begin
                port_rec[p].cause = ITI_CAUSE_LEN'(cause_i);
                port_rec[p].tval  = ITI_XLEN'(tval_i);
            end
        end
    end

    // Compaction: slot k takes the valid port whose prefix count equals k.
    always_comb begin
        push_data = '0;
        for (int k = 0; k < NP; k++) begin
            for (int p = 0; p < NP; p++) begin
                if (valid_i[p] && (pre[p] == CW'(k))) begin
                    push_data[k] = port_rec[p];
                end
            end
        end
        push_data[0].lost = lost_pending_q;
    end

    // Commit cannot stall, so a cycle that does not fit is dropped whole.
    always_comb begin
        capture  = (state_q == ITI_SCHED_ACTIVE) && trace_enable_i;
        overflow = capture && (FW'(nvalid) > free);
        push_cnt = (capture && !overflow) ? nvalid : '0;
        pop      = fifo_valid && out_ready_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ITI_SCHED_OFF;
            busy_q         <= 1'b0;
            lost_pending_q <= 1'b0;
        end else begin
            case (state_q)
                ITI_SCHED_OFF: begin
                    lost_pending_q <= 1'b0;
                    if (trace_enable_i) begin
                        state_q <= ITI_SCHED_ACTIVE;
                        busy_q  <= 1'b1;
                    end
                end
                ITI_SCHED_ACTIVE: begin
                    if (overflow) begin
                        lost_pending_q <= 1'b1;
                    end else if (push_cnt != '0) begin
                        lost_pending_q <= 1'b0;
                    end
                    if (!trace_enable_i) begin
                        state_q <= ITI_SCHED_DRAIN;
                    end
                end
                ITI_SCHED_DRAIN: begin
                    if (trace_enable_i) begin
                        state_q <= ITI_SCHED_ACTIVE;
                    end else if (fill == '0) begin
                        state_q <= ITI_SCHED_OFF;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ITI_SCHED_OFF;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ITI_SCHED_DROP_CNT_EN
    logic [31:0] drop_cnt_q;
    logic [32:0] drop_sum;

    assign drop_sum = {1'b0, drop_cnt_q} + 33'(nvalid);

    // Saturating count of dropped records, restarted on each trace session.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_q <= '0;
        end else if ((state_q == ITI_SCHED_OFF) && trace_enable_i) begin
            drop_cnt_q <= '0;
        end else if (overflow) begin
            drop_cnt_q <= drop_sum[32] ? '1 : drop_sum[31:0];
        end
    end

    assign drop_count_o = drop_cnt_q;
`else
    assign drop_count_o = '0;
`endif

    iti_multi_push_fifo #(
        .NP    (NP),
        .DEPTH (FIFO_DEPTH),
        .rec_t (iti_sched_rec_t)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_cnt_i  (push_cnt),
        .push_data_i (push_data),
        .pop_i       (pop),
        .free_o      (free),
        .fill_o      (fill),
        .valid_o     (fifo_valid),
        .head_o      (head)
    );

    assign out_valid_o     = fifo_valid;
    assign out_iretire_o   = IRETIRE_LEN'(head.iretire);
    assign out_itype_o     = ITYPE_LEN'(head.itype);
    assign out_ilastsize_o = head.ilastsize;
    assign out_iaddr_o     = XLEN'(head.iaddr);
    assign out_priv_o      = head.priv;
    assign out_cause_o     = CAUSE_LEN'(head.cause);
    assign out_tval_o      = XLEN'(head.tval);
    assign out_cycles_o    = head.cycles;
    assign out_lost_o      = head.lost;
    assign fill_o          = fill;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_iti_trace_scheduler.sv
// Directed bench for iti_trace_scheduler (NP=2, XLEN=32, FIFO_DEPTH=8).
module tb_iti_trace_scheduler;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              trace_enable;
    logic [1:0]        valid_i;
    logic [1:0][31:0]  iretire_i;
    logic [1:0][2:0]   itype_i;
    logic [1:0]        ilastsize_i;
    logic [1:0][31:0]  iaddr_i;
    logic [1:0]        priv_i;
    logic [4:0]        cause_i;
    logic [31:0]       tval_i;
    logic [63:0]       cycles_i;
    logic              out_valid, out_ready;
    logic [31:0]       out_iretire;
    logic [2:0]        out_itype;
    logic              out_ilastsize;
    logic [31:0]       out_iaddr;
    logic [1:0]        out_priv;
    logic [4:0]        out_cause;
    logic [31:0]       out_tval;
    logic [63:0]       out_cycles;
    logic              out_lost;
    logic [3:0]        fill;
    logic              busy;
    logic [31:0]       drop_count;

    int n_vec = 0;
    int n_err = 0;

`ifdef ITI_SCHED_DROP_CNT_EN
    localparam logic [31:0] EXP_DROP = 32'd2;
`else
    localparam logic [31:0] EXP_DROP = 32'd0;
`endif

    iti_trace_scheduler dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .trace_enable_i  (trace_enable),
        .valid_i         (valid_i),
        .iretire_i       (iretire_i),
        .itype_i         (itype_i),
        .ilastsize_i     (ilastsize_i),
        .iaddr_i         (iaddr_i),
        .priv_i          (priv_i),
        .cause_i         (cause_i),
        .tval_i          (tval_i),
        .cycles_i        (cycles_i),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_iretire_o   (out_iretire),
        .out_itype_o     (out_itype),
        .out_ilastsize_o (out_ilastsize),
        .out_iaddr_o     (out_iaddr),
        .out_priv_o      (out_priv),
        .out_cause_o     (out_cause),
        .out_tval_o      (out_tval),
        .out_cycles_o    (out_cycles),
        .out_lost_o      (out_lost),
        .fill_o          (fill),
        .busy_o          (busy),
        .drop_count_o    (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1);
        valid_i    = v;
        iaddr_i[0] = a0;
        iaddr_i[1] = a1;
    endtask

    initial begin
        rst_n        = 1'b0;
        trace_enable = 1'b0;
        out_ready    = 1'b0;
        valid_i      = '0;
        iretire_i    = '0;
        itype_i      = '0;
        ilastsize_i  = '0;
        iaddr_i      = '0;
        priv_i       = '0;
        cause_i      = '0;
        tval_i       = '0;
        cycles_i     = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_fill",  64'(fill),      64'd0);
        chk("rst_busy",  64'(busy),      64'd0);
        chk("rst_drop",  64'(drop_count), 64'd0);
        chk("rst_iaddr", 64'(out_iaddr), 64'd0);
        rst_n = 1'b1;
        tick();

        // Enable, then a single port-0 record streamed straight through.
        trace_enable = 1'b1;
        tick();
        chk("en_busy", 64'(busy), 64'd1);
        chk("en_valid", 64'(out_valid), 64'd0);
        drive(2'b01, 32'h8000_0000, 32'h0);
        out_ready = 1'b1;
        tick();
        chk("p0_valid", 64'(out_valid), 64'd1);
        chk("p0_iaddr", 64'(out_iaddr), 64'h8000_0000);
        chk("p0_lost",  64'(out_lost),  64'd0);
        chk("p0_fill",  64'(fill),      64'd1);
        drive(2'b00, 32'h0, 32'h0);
        tick();
        chk("p0_fill0",  64'(fill),      64'd0);
        chk("p0_valid0", 64'(out_valid), 64'd0);

        // Two ports in one cycle: port order kept, cause/tval only on port 0.
        drive(2'b11, 32'h100, 32'h104);
        cause_i = 5'd3; tval_i = 32'h55; priv_i = 2'd3; cycles_i = 64'h1234;
        iretire_i[0] = 32'd5; iretire_i[1] = 32'd7;
        itype_i[0] = 3'd2; itype_i[1] = 3'd1;
        ilastsize_i = 2'b01;
        tick();
        drive(2'b00, 32'h0, 32'h0);
        cause_i = '0; tval_i = '0; priv_i = '0; cycles_i = '0;
        chk("pair_fill",   64'(fill),          64'd2);
        chk("pair0_iaddr", 64'(out_iaddr),     64'h100);
        chk("pair0_cause", 64'(out_cause),     64'd3);
        chk("pair0_tval",  64'(out_tval),      64'h55);
        chk("pair0_priv",  64'(out_priv),      64'd3);
        chk("pair0_cyc",   out_cycles,         64'h1234);
        chk("pair0_iret",  64'(out_iretire),   64'd5);
        chk("pair0_ityp",  64'(out_itype),     64'd2);
        chk("pair0_ilsz",  64'(out_ilastsize), 64'd1);
        tick();
        chk("pair1_iaddr", 64'(out_iaddr),     64'h104);
        chk("pair1_cause", 64'(out_cause),     64'd0);
        chk("pair1_tval",  64'(out_tval),      64'd0);
        chk("pair1_priv",  64'(out_priv),      64'd3);
        chk("pair1_cyc",   out_cycles,         64'h1234);
        chk("pair1_iret",  64'(out_iretire),   64'd7);
        chk("pair1_ilsz",  64'(out_ilastsize), 64'd0);
        tick();
        chk("pair_fill0", 64'(fill), 64'd0);

        // Fill to capacity, overflow drops the whole cycle, lost flag follows.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 32'(16 * (i + 1)), 32'(16 * (i + 1) + 4));
            tick();
        end
        chk("full_fill",  64'(fill),      64'd8);
        chk("full_head",  64'(out_iaddr), 64'h10);
        drive(2'b11, 32'hEE0, 32'hEE4);
        tick();
        chk("ovf_fill",  64'(fill),       64'd8);
        chk("ovf_hold",  64'(out_iaddr),  64'h10);
        chk("ovf_drop",  64'(drop_count), 64'(EXP_DROP));
        drive(2'b00, 32'h0, 32'h0);
        out_ready = 1'b1;
        tick();
        chk("pop_fill", 64'(fill),      64'd7);
        chk("pop_head", 64'(out_iaddr), 64'h14);
        drive(2'b01, 32'h200, 32'h0);
        tick();
        drive(2'b00, 32'h0, 32'h0);
        chk("lostpush_fill", 64'(fill),      64'd7);
        chk("lostpush_head", 64'(out_iaddr), 64'h20);
        chk("lostpush_lost", 64'(out_lost),  64'd0);
        repeat (6) tick();
        chk("lost_iaddr", 64'(out_iaddr), 64'h200);
        chk("lost_flag",  64'(out_lost),  64'd1);
        chk("lost_fill",  64'(fill),      64'd1);
        tick();
        chk("lost_empty", 64'(out_valid), 64'd0);

        // Drain after enable falls, inputs ignored, then back to OFF.
        out_ready = 1'b0;
        drive(2'b11, 32'h300, 32'h304);
        tick();
        drive(2'b01, 32'h308, 32'h0);
        tick();
        chk("drn_fill3", 64'(fill), 64'd3);
        trace_enable = 1'b0;
        drive(2'b11, 32'h3F0, 32'h3F4);
        tick();
        chk("drn_fill_a", 64'(fill), 64'd3);
        chk("drn_busy_a", 64'(busy), 64'd1);
        tick();
        chk("drn_fill_b", 64'(fill),      64'd3);
        chk("drn_valid",  64'(out_valid), 64'd1);
        chk("drn_head",   64'(out_iaddr), 64'h300);
        out_ready = 1'b1;
        drive(2'b00, 32'h0, 32'h0);
        tick();
        chk("drn_r1", 64'(out_iaddr), 64'h304);
        chk("drn_f1", 64'(fill),      64'd2);
        tick();
        chk("drn_r2", 64'(out_iaddr), 64'h308);
        tick();
        chk("drn_f0",    64'(fill), 64'd0);
        chk("drn_busy1", 64'(busy), 64'd1);
        tick();
        chk("drn_off", 64'(busy), 64'd0);

        // Re-enable during drain: queued records first, rising-cycle inputs lost.
        trace_enable = 1'b1;
        tick();
        out_ready = 1'b0;
        drive(2'b11, 32'h400, 32'h404);
        tick();
        trace_enable = 1'b0;
        drive(2'b00, 32'h0, 32'h0);
        tick();
        chk("re_fill_drain", 64'(fill), 64'd2);
        trace_enable = 1'b1;
        drive(2'b11, 32'h4F0, 32'h4F4);
        tick();
        chk("re_fill", 64'(fill), 64'd2);
        chk("re_busy", 64'(busy), 64'd1);
        chk("re_head", 64'(out_iaddr), 64'h400);
        drive(2'b01, 32'h500, 32'h0);
        out_ready = 1'b1;
        tick();
        drive(2'b00, 32'h0, 32'h0);
        chk("re_r1", 64'(out_iaddr), 64'h404);
        chk("re_f1", 64'(fill),      64'd2);
        tick();
        chk("re_r2",   64'(out_iaddr), 64'h500);
        chk("re_lost", 64'(out_lost),  64'd0);
        tick();
        chk("re_f0", 64'(fill), 64'd0);

        // Asynchronous reset mid-cycle with records buffered.
        out_ready = 1'b0;
        drive(2'b11, 32'h600, 32'h604);
        tick();
        tick();
        drive(2'b01, 32'h610, 32'h0);
        tick();
        drive(2'b00, 32'h0, 32'h0);
        chk("ar_fill5", 64'(fill), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_fill",  64'(fill),      64'd0);
        chk("ar_busy",  64'(busy),      64'd0);
        trace_enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("ar_post_fill", 64'(fill), 64'd0);
        chk("ar_post_busy", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
